// File: rtl/matrix_pkg.sv
// matrix_pkg: constants, types and helpers shared by the matrix streaming blocks.
package matrix_pkg;

    // Default matrix order and element width used by the matrix blocks.
    localparam int MATRIX_SIZE_DEFAULT       = 32'sd4;
    localparam int MATRIX_DATA_WIDTH_DEFAULT = 32'sd32;

    // Row/column index wide enough for the largest supported order (64).
    typedef logic [5:0] matrix_idx_t;

    // Number of elements stored in a packed upper-triangular N x N matrix.
    function automatic int tri_count(input int n);
        return (n * (n + 32'sd1)) / 32'sd2;
    endfunction

endpackage

// File: rtl/upper_tri_expand.sv
// upper_tri_expand: expands a row-major packed upper-triangular stream
// (diagonal included) into a full row-major N x N stream, zero-filling
// the strictly lower triangle. One registered output stage, 1 beat/cycle.
// Optional out_tlast (last element of each matrix) is enabled by defining
// the macro UPPER_TRI_EXPAND_TLAST_EN.
module upper_tri_expand
    import matrix_pkg::*;
#(
    parameter int SIZE       = MATRIX_SIZE_DEFAULT,
    parameter int DATA_WIDTH = MATRIX_DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready
`ifdef UPPER_TRI_EXPAND_TLAST_EN
    ,
    output logic                  out_tlast
`endif
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    logic [IDX_W-1:0]      r_q, r_d;
    logic [IDX_W-1:0]      c_q, c_d;
    logic [DATA_WIDTH-1:0] out_tdata_q, out_tdata_d;
    logic                  out_tvalid_q, out_tvalid_d;
    logic                  load_s;
    logic                  pass_s;
    logic                  adv_s;
`ifdef UPPER_TRI_EXPAND_TLAST_EN
    logic                  out_tlast_q, out_tlast_d;
`endif

    // Slot classification, output-register next state and position advance.
    always_comb begin
        load_s       = !out_tvalid_q || out_tready;
        pass_s       = (c_q >= r_q);
        // The register is (re)loaded on every fill slot, or on a pass slot with data.
        adv_s        = load_s && (!pass_s || in_tvalid);
        out_tdata_d  = out_tdata_q;
        out_tvalid_d = out_tvalid_q;
        r_d          = r_q;
        c_d          = c_q;
`ifdef UPPER_TRI_EXPAND_TLAST_EN
        out_tlast_d  = out_tlast_q;
`endif
        if (load_s) begin
            if (pass_s && in_tvalid) begin
                out_tdata_d  = in_tdata;
                out_tvalid_d = 1'b1;
            end else if (!pass_s) begin
                out_tdata_d  = '0;
                out_tvalid_d = 1'b1;
            end else begin
                // Pass slot starved: drop valid, keep the last data bits.
                out_tvalid_d = 1'b0;
            end
        end else begin
            // Downstream stalled: hold everything.
            out_tvalid_d = out_tvalid_q;
        end
        if (adv_s) begin
`ifdef UPPER_TRI_EXPAND_TLAST_EN
            out_tlast_d = (r_q == LAST_IDX) && (c_q == LAST_IDX);
`endif
            if (c_q == LAST_IDX) begin
                c_d = '0;
                if (r_q == LAST_IDX) begin
                    r_d = '0;
                end else begin
                    r_d = r_q + IDX_W'(1);
                end
            end else begin
                c_d = c_q + IDX_W'(1);
            end
        end else begin
            c_d = c_q;
        end
    end

    // Position counters and output register; reset discards any partial matrix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q          <= '0;
            c_q          <= '0;
            out_tdata_q  <= '0;
            out_tvalid_q <= 1'b0;
`ifdef UPPER_TRI_EXPAND_TLAST_EN
            out_tlast_q  <= 1'b0;
`endif
        end else begin
            r_q          <= r_d;
            c_q          <= c_d;
            out_tdata_q  <= out_tdata_d;
            out_tvalid_q <= out_tvalid_d;
`ifdef UPPER_TRI_EXPAND_TLAST_EN
            out_tlast_q  <= out_tlast_d;
`endif
        end
    end

    // Input is only accepted on pass slots while the output register can load.
    assign in_tready  = load_s && pass_s;
    assign out_tdata  = out_tdata_q;
    assign out_tvalid = out_tvalid_q;
`ifdef UPPER_TRI_EXPAND_TLAST_EN
    assign out_tlast  = out_tlast_q;
`endif

endmodule

// File: tb/tb_upper_tri_expand.sv
// tb_upper_tri_expand: directed, scoreboard-based bench for upper_tri_expand
// (SIZE=4, DATA_WIDTH=32). Define UPPER_TRI_EXPAND_TLAST_EN to also check out_tlast.
module tb_upper_tri_expand;

    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic [DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b1;
`ifdef UPPER_TRI_EXPAND_TLAST_EN
    logic          out_tlast;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   n_out = 0;

    upper_tri_expand #(.SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
`ifdef UPPER_TRI_EXPAND_TLAST_EN
        ,
        .out_tlast  (out_tlast)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected full matrix built from packed values base+1 .. base+N(N+1)/2.
    task automatic push_matrix(input int base);
        int k;
        exp_t e;
        k = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c >= r) begin
                    e.data = DW'(base + 1 + k);
                    k++;
                end else begin
                    e.data = '0;
                end
                e.last = (r == N - 1) && (c == N - 1);
                sb.push_back(e);
            end
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [DW-1:0] v);
        bit acc;
        acc = 1'b0;
        in_tvalid = 1'b1;
        in_tdata  = v;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_tready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_matrix(input int base, input bit gap);
        for (int k = 0; k < N * (N + 1) / 2; k++) begin
            send(DW'(base + 1 + k));
            if (gap) begin
                in_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 200 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk(tag, DW'(sb.size()), 32'd0);
    endtask

    // Output monitor: every output handshake is compared to the scoreboard head.
    always @(negedge clk) begin
        if (rst && out_tvalid && out_tready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", out_tdata, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", out_tdata, mon_e.data);
`ifdef UPPER_TRI_EXPAND_TLAST_EN
                chk("out_last", DW'(out_tlast), DW'(mon_e.last));
`endif
            end
            if (n_out == 0) first_cyc = cyc;
            last_cyc = cyc;
            n_out++;
        end
    end

    initial begin
        int tr;
        int tc;
        int k;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", DW'(out_tvalid), 32'd0);
        chk("rst_data", out_tdata, 32'd0);
`ifdef UPPER_TRI_EXPAND_TLAST_EN
        chk("rst_last", DW'(out_tlast), 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", DW'(in_tready), 32'd1);

        // One matrix back-to-back
        n_out = 0;
        push_matrix(0);
        send_matrix(0, 1'b0);
        drain("t1_drain");
        chk("t1_count", DW'(n_out), 32'd16);
        chk("t1_span", DW'(last_cyc - first_cyc), 32'd15);

        // Two matrices back-to-back, no idle cycle between them
        n_out = 0;
        push_matrix(0);
        push_matrix(10);
        send_matrix(0, 1'b0);
        send_matrix(10, 1'b0);
        drain("t2_drain");
        chk("t2_count", DW'(n_out), 32'd32);
        chk("t2_span", DW'(last_cyc - first_cyc), 32'd31);

        // Back-pressure for 3 cycles while 5 is on the output
        n_out = 0;
        push_matrix(0);
        fork
            send_matrix(0, 1'b0);
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 100 && !seen; t++) begin
                    @(posedge clk);
                    #1;
                    seen = out_tvalid && (out_tdata == 32'd5);
                end
                chk("t3_saw5", DW'(seen), 32'd1);
                out_tready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("t3_hold_data", out_tdata, 32'd5);
                    chk("t3_hold_valid", DW'(out_tvalid), 32'd1);
                    chk("t3_ready_low", DW'(in_tready), 32'd0);
                end
                @(posedge clk);
                #1;
                out_tready = 1'b1;
            end
        join
        drain("t3_drain");
        chk("t3_count", DW'(n_out), 32'd16);

        // in_tvalid toggling
        n_out = 0;
        push_matrix(0);
        send_matrix(0, 1'b1);
        drain("t4_drain");
        chk("t4_count", DW'(n_out), 32'd16);

        // Reset mid-matrix after 6 outputs
        n_out = 0;
        push_matrix(0);
        while (sb.size() > 6) void'(sb.pop_back());
        for (int v = 1; v <= 6; v++) send(DW'(v));
        in_tvalid = 1'b0;
        drain("t5_pre_drain");
        chk("t5_pre_count", DW'(n_out), 32'd6);
        chk("t5_pre_valid", DW'(out_tvalid), 32'd1);
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", DW'(out_tvalid), 32'd0);
        chk("t5_rst_data", out_tdata, 32'd0);
        #2;
        rst = 1'b1;
        n_out = 0;
        push_matrix(0);
        send_matrix(0, 1'b0);
        drain("t5_drain");
        chk("t5_count", DW'(n_out), 32'd16);

        // 0xDEAD presented with valid during fill slots must not be consumed
        n_out = 0;
        push_matrix(20);
        tr = 0;
        tc = 0;
        k = 0;
        @(posedge clk);
        #1;
        for (int s = 0; s < N * N; s++) begin
            in_tvalid = 1'b1;
            in_tdata  = (tc >= tr) ? DW'(21 + k) : 32'h0000_DEAD;
            @(negedge clk);
            chk("t6_ready", DW'(in_tready), DW'(tc >= tr));
            if (in_tready && (tc >= tr)) k++;
            if (tc == N - 1) begin
                tc = 0;
                tr = (tr == N - 1) ? 0 : tr + 1;
            end else begin
                tc++;
            end
            @(posedge clk);
            #1;
        end
        in_tvalid = 1'b0;
        drain("t6_drain");
        chk("t6_count", DW'(n_out), 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
